// File: rtl/instr_loader.sv
// Instruction loader. Accepts 32-bit instruction words over a valid/ready
// handshake and writes each word into a byte-wide instruction memory in
// big-endian order. Four consecutive write cycles follow each accepted word.
// A word that would extend past the last memory location is dropped, and the
// session ends with the sticky overflow flag set.
module instr_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic                     in_valid,
    input  logic [31:0]              in_word,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [ADDRESS_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE
    } state_t;

    // Highest legal byte address. It is one bit wider than the pointer, so
    // the bounds check cannot wrap.
    localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = (ADDRESS_WIDTH+1)'(DEPTH - 1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [31:0]              word_q, word_d;
    logic                     last_q, last_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     overflow_q, overflow_d;
    logic [ADDRESS_WIDTH-1:0] word_count_q, word_count_d;

    logic [ADDRESS_WIDTH:0]   ptr_plus3;
    logic                     word_fits;
    logic                     transfer;
    logic [1:0]               next_cnt;

    assign ptr_plus3 = {1'b0, ptr_q} + (ADDRESS_WIDTH+1)'(3);
    assign word_fits = (ptr_plus3 <= LAST_ADDR);
    assign transfer  = in_valid && in_ready_q;
    assign next_cnt  = byte_cnt_q + 2'd1;

    // Big-endian byte select: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Next-state and next-output logic for the load FSM.
    always_comb begin
        // NOTE: every _d starts from a default, so no path leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        ptr_d        = ptr_q;
        word_d       = word_q;
        last_d       = last_q;
        byte_cnt_d   = byte_cnt_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        in_ready_d   = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d        = base_addr;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    state_d      = WAIT_WORD;
                    in_ready_d   = 1'b1;
                    busy_d       = 1'b1;
                end
            end

            WAIT_WORD: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
                if (transfer) begin
                    in_ready_d = 1'b0;
                    if (word_fits) begin
                        word_d     = in_word;
                        last_d     = in_last;
                        byte_cnt_d = 2'd0;
                        state_d    = WRITE;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = DATA_WIDTH'(word_byte(in_word, 2'd0));
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end

            WRITE: begin
                busy_d = 1'b1;
                if (byte_cnt_q == 2'd3) begin
                    ptr_d        = ptr_q + ADDRESS_WIDTH'(4);
                    word_count_d = word_count_q + ADDRESS_WIDTH'(1);
                    if (last_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = WAIT_WORD;
                        in_ready_d = 1'b1;
                    end
                end else begin
                    byte_cnt_d = next_cnt;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = ptr_q + ADDRESS_WIDTH'(next_cnt);
                    wr_data_d  = DATA_WIDTH'(word_byte(word_q, next_cnt));
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset returns everything to idle zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            byte_cnt_q   <= 2'd0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from pre-edge values.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            word_q       <= word_d;
            last_q       <= last_d;
            byte_cnt_q   <= byte_cnt_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule
